// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with deglitch filter, frame FSM and read FIFO
// Define PS2_RX_TIMEOUT_EN to build the stalled-frame timeout abort.
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       slowClk,
  input  logic       reset,
  input  logic       PS2clk,
  input  logic       PS2data,
  output logic [7:0] rxData,
  output logic       rxParityErr,
  output logic       rxValid,
  input  logic       rxReady,
  input  logic       clearErr,
  output logic       overflow,
  output logic       frameErr,
  output logic       parityErr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t      state;
  logic        clkS1, clkS2, datS1, datS2, fClk, fall;
  logic [3:0]  fCnt;
  logic [2:0]  bitCnt;
  logic [7:0]  shreg;
  logic        parBad;
  logic        push, abort;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr, rdNext;
  logic [AW:0]   count, countNext;
  logic          full, doPush, doPop;

  // fClk only follows clkS2 after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge slowClk or negedge reset) begin
    if (!reset) begin
      clkS1 <= 1'b1;
      clkS2 <= 1'b1;
      datS1 <= 1'b1;
      datS2 <= 1'b1;
      fClk  <= 1'b1;
      fCnt  <= 4'd0;
      fall  <= 1'b0;
    end else begin
      clkS1 <= PS2clk;
      clkS2 <= clkS1;
      datS1 <= PS2data;
      datS2 <= datS1;
      fall  <= 1'b0;
      if (clkS2 == fClk) begin
        fCnt <= 4'd0;
      end else if (fCnt == 4'(FILTER_LEN - 1)) begin
        fClk <= clkS2;
        fCnt <= 4'd0;
        fall <= fClk;
      end else begin
        fCnt <= fCnt + 4'd1;
      end
    end
  end

  assign push = fall && (state == STOP) && datS2;

`ifdef PS2_RX_TIMEOUT_EN
  logic [15:0] toCnt;

  always_ff @(posedge slowClk or negedge reset) begin
    if (!reset) begin
      toCnt <= 16'd0;
    end else if (fall || state == IDLE) begin
      toCnt <= 16'd0;
    end else if (toCnt != TO_MAX) begin
      toCnt <= toCnt + 16'd1;
    end
  end

  assign abort = (state != IDLE) && !fall && (toCnt == TO_MAX);
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TO_MAX;
  assign abort = 1'b0;
`endif

  // Flag sets are written after the clear so a coincident set wins
  always_ff @(posedge slowClk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bitCnt    <= 3'd0;
      shreg     <= 8'd0;
      parBad    <= 1'b0;
      frameErr  <= 1'b0;
      parityErr <= 1'b0;
    end else begin
      if (clearErr) begin
        frameErr  <= 1'b0;
        parityErr <= 1'b0;
      end
      if (abort) begin
        state    <= IDLE;
        frameErr <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!datS2) begin
              state  <= DATA;
              bitCnt <= 3'd0;
            end else begin
              frameErr <= 1'b1;
            end
          end
          DATA: begin
            shreg  <= {datS2, shreg[7:1]};
            bitCnt <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parBad <= ~(^shreg ^ datS2);
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (datS2) begin
              if (parBad) parityErr <= 1'b1;
            end else begin
              frameErr <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    doPop     = rxValid & rxReady;
    full      = (count == FULL_CNT);
    doPush    = push & (~full | doPop);
    rdNext    = doPop ? rdPtr + AW'(1) : rdPtr;
    countNext = count + (AW+1)'(doPush) - (AW+1)'(doPop);
  end

  always_ff @(posedge slowClk) begin
    if (doPush) mem[wrPtr] <= {parBad, shreg};
  end

  // Head register bypasses the array when the pushed entry becomes the head
  always_ff @(posedge slowClk or negedge reset) begin
    if (!reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      rxValid     <= 1'b0;
      rxData      <= 8'd0;
      rxParityErr <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (clearErr) overflow <= 1'b0;
      if (push && full && !doPop) overflow <= 1'b1;
      if (doPush) wrPtr <= wrPtr + AW'(1);
      rdPtr   <= rdNext;
      count   <= countNext;
      rxValid <= (countNext != '0);
      if (countNext != '0) begin
        if (doPush && rdNext == wrPtr) {rxParityErr, rxData} <= {parBad, shreg};
        else                           {rxParityErr, rxData} <= mem[rdNext];
      end
    end
  end

endmodule
